// File: rtl/apb_master_fsm.sv
// APB3 master sequencer: pops {write, addr, wdata} requests, runs one APB3 transfer each, pushes {slverr, rdata}.
// Optional ACCESS watchdog is built only when APB_TIMEOUT_EN is defined.
module apb_master_fsm #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                     pclk,
    input  logic                     prst_n,
    input  logic [ADDR_W+DATA_W:0]   req_rdata,
    input  logic                     req_rempty,
    output logic                     req_rinc,
    output logic [DATA_W:0]          resp_wdata,
    input  logic                     resp_wfull,
    output logic                     resp_winc,
    output logic                     psel,
    output logic                     penable,
    output logic                     pwrite,
    output logic [ADDR_W-1:0]        paddr,
    output logic [DATA_W-1:0]        pwdata,
    input  logic [DATA_W-1:0]        prdata,
    input  logic                     pready,
    input  logic                     pslverr,
    output logic                     busy,
    output logic                     timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t state;
    logic   expire;

    // The FIFO read data is registered, so the popped word is sampled one cycle later in LOAD.
    assign req_rinc  = prst_n && (state == S_IDLE) && !req_rempty;
    assign resp_winc = (state == S_RESP) && !resp_wfull;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] access_cnt;

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            access_cnt <= '0;
        end else if (state == S_SETUP) begin
            access_cnt <= '0;
        end else if ((state == S_ACCESS) && !pready) begin
            access_cnt <= access_cnt + CNT_W'(1);
        end
    end

    assign expire  = (state == S_ACCESS) && !pready &&
                     (access_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout = expire;
`else
    assign expire  = 1'b0 & (TIMEOUT_CYCLES == 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state      <= S_IDLE;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            resp_wdata <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!req_rempty) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    pwrite <= req_rdata[ADDR_W+DATA_W];
                    paddr  <= req_rdata[ADDR_W+DATA_W-1:DATA_W];
                    pwdata <= req_rdata[DATA_W-1:0];
                    psel   <= 1'b1;
                    state  <= S_SETUP;
                end
                S_SETUP: begin
                    penable <= 1'b1;
                    state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    // A late pready on the expiry cycle still completes normally.
                    if (pready) begin
                        resp_wdata <= {pslverr, (pwrite ? {DATA_W{1'b0}} : prdata)};
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                        state      <= S_RESP;
                    end else if (expire) begin
                        resp_wdata <= {1'b1, {DATA_W{1'b0}}};
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (!resp_wfull) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_fsm.sv
// Directed bench for apb_master_fsm with a registered-read request FIFO model and a logging response sink.
module tb_apb_master_fsm;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic                   pclk;
    logic                   prst_n;
    logic [ADDR_W+DATA_W:0] req_rdata;
    logic                   req_rempty;
    logic                   req_rinc;
    logic [DATA_W:0]        resp_wdata;
    logic                   resp_wfull;
    logic                   resp_winc;
    logic                   psel;
    logic                   penable;
    logic                   pwrite;
    logic [ADDR_W-1:0]      paddr;
    logic [DATA_W-1:0]      pwdata;
    logic [DATA_W-1:0]      prdata;
    logic                   pready;
    logic                   pslverr;
    logic                   busy;
    logic                   timeout;

    apb_master_fsm #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .pclk      (pclk),
        .prst_n    (prst_n),
        .req_rdata (req_rdata),
        .req_rempty(req_rempty),
        .req_rinc  (req_rinc),
        .resp_wdata(resp_wdata),
        .resp_wfull(resp_wfull),
        .resp_winc (resp_winc),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W+DATA_W:0] req_mem [16];
    logic [DATA_W:0]        resp_log [16];
    int rd_ptr = 0;
    int wr_ptr = 0;
    int pop_cnt = 0;
    int push_cnt = 0;
    int illegal_pop = 0;
    int illegal_push = 0;
    int en_viol = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic enqueue(input logic [ADDR_W+DATA_W:0] w);
        req_mem[wr_ptr] = w;
        wr_ptr++;
        req_rempty = 1'b0;
    endtask

    // One clock: sample handshakes mid-cycle, then model the FIFO reaction to the edge.
    task automatic tick();
        logic           pop_s;
        logic           push_s;
        logic [DATA_W:0] d;
        @(negedge pclk);
        pop_s  = req_rinc;
        push_s = resp_winc;
        d      = resp_wdata;
        if (pop_s && req_rempty) illegal_pop++;
        if (push_s && resp_wfull) illegal_push++;
        if (penable && !psel) en_viol++;
        @(posedge pclk);
        #1;
        if (pop_s) begin
            req_rdata = req_mem[rd_ptr];
            rd_ptr++;
            pop_cnt++;
        end
        if (push_s) begin
            resp_log[push_cnt] = d;
            push_cnt++;
        end
        req_rempty = (rd_ptr == wr_ptr);
        #1;
    endtask

    task automatic wait_psel();
        for (int i = 0; i < 12 && psel !== 1'b1; i++) tick();
        check("wait_psel", psel, 1);
    endtask

    task automatic wait_push(input int target);
        for (int i = 0; i < 40 && push_cnt < target; i++) tick();
        check("wait_push", push_cnt, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        int q0;
        int low_run;
        int min_gap;
        bit seen_xfer;
        logic [ADDR_W-1:0] a;

        prst_n     = 1'b0;
        req_rdata  = '0;
        req_rempty = 1'b0;
        resp_wfull = 1'b0;
        prdata     = '0;
        pready     = 1'b0;
        pslverr    = 1'b0;
        #3;
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_resp_wdata", resp_wdata, 0);
        check("rst_rinc", req_rinc, 0);
        req_rempty = 1'b1;
        @(posedge pclk);
        #1;
        prst_n = 1'b1;
        #1;

        // Zero-wait read
        enqueue({1'b0, 32'h0000_0010, 32'hDEAD_BEEF});
        #1;
        check("t1_idle_rinc", req_rinc, 1);
        tick();
        check("t1_load_busy", busy, 1);
        check("t1_load_psel", psel, 0);
        check("t1_load_rinc", req_rinc, 0);
        tick();
        check("t1_setup_psel", psel, 1);
        check("t1_setup_penable", penable, 0);
        check("t1_setup_paddr", paddr, 32'h10);
        check("t1_setup_pwrite", pwrite, 0);
        tick();
        check("t1_access_psel", psel, 1);
        check("t1_access_penable", penable, 1);
        pready = 1'b1;
        prdata = 32'hCAFE_F00D;
        tick();
        pready = 1'b0;
        prdata = '0;
        #1;
        check("t1_resp_psel", psel, 0);
        check("t1_resp_penable", penable, 0);
        check("t1_resp_winc", resp_winc, 1);
        check("t1_resp_wdata", resp_wdata, 33'h0_CAFE_F00D);
        tick();
        check("t1_push_cnt", push_cnt, 1);
        check("t1_pop_cnt", pop_cnt, 1);
        check("t1_push_data", resp_log[0], 33'h0_CAFE_F00D);
        check("t1_idle_busy", busy, 0);

        // Wait-state write with slave error
        enqueue({1'b1, 32'h0000_0024, 32'h1234_5678});
        tick();
        tick();
        check("t2_setup_psel", psel, 1);
        check("t2_setup_paddr", paddr, 32'h24);
        check("t2_setup_pwrite", pwrite, 1);
        check("t2_setup_pwdata", pwdata, 32'h1234_5678);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t2_wait_penable", penable, 1);
            check("t2_wait_pwdata", pwdata, 32'h1234_5678);
            check("t2_wait_timeout", timeout, 0);
            tick();
        end
        check("t2_acc4_penable", penable, 1);
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hFFFF_FFFF;
        tick();
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        #1;
        check("t2_resp_psel", psel, 0);
        check("t2_resp_wdata", resp_wdata, 33'h1_0000_0000);
        check("t2_hold_pwdata", pwdata, 32'h1234_5678);
        tick();
        check("t2_push_data", resp_log[1], 33'h1_0000_0000);

        // Back-to-back reads, one every five cycles
        for (int k = 0; k < 4; k++) enqueue({1'b0, 32'h100 + 32'(4 * k), 32'h0});
        pready    = 1'b1;
        low_run   = 0;
        min_gap   = 99;
        seen_xfer = 1'b0;
        for (int i = 0; i < 20; i++) begin
            prdata = {16'hBEEF, paddr[15:0]};
            tick();
            if (psel) begin
                if (seen_xfer && low_run > 0 && low_run < min_gap) min_gap = low_run;
                seen_xfer = 1'b1;
                low_run   = 0;
            end else if (seen_xfer) begin
                low_run++;
            end
            if (i == 18) check("t3_push_19", push_cnt, 5);
        end
        pready = 1'b0;
        prdata = '0;
        check("t3_push_cnt", push_cnt, 6);
        check("t3_pop_cnt", pop_cnt, 6);
        check("t3_gap_ge2", (min_gap >= 2 && min_gap != 99), 1);
        for (int k = 0; k < 4; k++) begin
            a = 32'h100 + 32'(4 * k);
            check("t3_order", resp_log[2 + k], {1'b0, 16'hBEEF, a[15:0]});
        end

        // Response backpressure with a second request waiting
        enqueue({1'b0, 32'h0000_0030, 32'h0});
        enqueue({1'b0, 32'h0000_0034, 32'h0});
        wait_psel();
        tick();
        pready     = 1'b1;
        prdata     = 32'h55AA_55AA;
        resp_wfull = 1'b1;
        tick();
        pready = 1'b0;
        prdata = '0;
        p0 = pop_cnt;
        q0 = push_cnt;
        for (int i = 0; i < 5; i++) begin
            check("t4_full_winc", resp_winc, 0);
            check("t4_full_busy", busy, 1);
            check("t4_full_rinc", req_rinc, 0);
            tick();
        end
        resp_wfull = 1'b0;
        #1;
        check("t4_release_winc", resp_winc, 1);
        check("t4_no_pop", pop_cnt, p0);
        tick();
        check("t4_push_once", push_cnt, q0 + 1);
        check("t4_push_data", resp_log[q0], 33'h0_55AA_55AA);
        pready = 1'b1;
        prdata = 32'h0000_0077;
        wait_push(q0 + 2);
        check("t4_second_data", resp_log[q0 + 1], 33'h0_0000_0077);
        pready = 1'b0;
        prdata = '0;

        // Reset during an ACCESS wait state
        enqueue({1'b1, 32'h0000_0040, 32'hA5A5_A5A5});
        wait_psel();
        tick();
        tick();
        check("t5_wait_penable", penable, 1);
        q0 = push_cnt;
        #2;
        prst_n = 1'b0;
        #1;
        check("t5_rst_psel", psel, 0);
        check("t5_rst_penable", penable, 0);
        check("t5_rst_busy", busy, 0);
        tick();
        prst_n = 1'b1;
        tick();
        check("t5_no_push", push_cnt, q0);
        check("t5_idle_busy", busy, 0);
        enqueue({1'b0, 32'h0000_0050, 32'h0});
        pready = 1'b1;
        prdata = 32'h0BAD_CAFE;
        wait_push(q0 + 1);
        check("t5_after_data", resp_log[q0], 33'h0_0BAD_CAFE);
        check("t5_after_paddr", paddr, 32'h50);
        pready = 1'b0;
        prdata = '0;

`ifdef APB_TIMEOUT_EN
        begin
            int acc;
            int pulses;
            acc    = 0;
            pulses = 0;
            enqueue({1'b0, 32'h0000_0060, 32'h0});
            wait_psel();
            tick();
            for (int i = 0; i < 20 && penable === 1'b1; i++) begin
                acc++;
                if (timeout) pulses++;
                tick();
            end
            check("t6_access_cycles", acc, 8);
            check("t6_timeout_pulses", pulses, 1);
            check("t6_resp_wdata", resp_wdata, 33'h1_0000_0000);
            q0 = push_cnt;
            wait_push(q0 + 1);
            check("t6_push_data", resp_log[q0], 33'h1_0000_0000);
        end
`endif

        check("no_illegal_pop", illegal_pop, 0);
        check("no_illegal_push", illegal_push, 0);
        check("penable_implies_psel", en_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_fsm.md
# apb_master_fsm

APB3 master sequencer on the APB-clock side of the AXI4-Lite to APB3 bridge. Pops packed requests from the read port of the request `fifo`, runs one APB3 transfer per request (SETUP, then ACCESS with PREADY wait states) and pushes a packed response into the write port of the response `fifo`. Strictly one outstanding transfer; requests complete in FIFO order.

## Interface
- `ADDR_W`, 32, APB address width.
- `DATA_W`, 32, APB data width.
- `TIMEOUT_CYCLES`, 256, maximum ACCESS cycles before forced termination; only used with `APB_TIMEOUT_EN`.
- `pclk` in 1: APB clock; all logic is on its rising edge.
- `prst_n` in 1: asynchronous, active-low reset.
- `req_rdata` in `ADDR_W+DATA_W+1`: request word `{write, addr, wdata}`, with `write` as the MSB.
- `req_rempty` in 1: request FIFO empty.
- `req_rinc` out 1: request FIFO pop.
- `resp_wdata` out `DATA_W+1`: response word `{slverr, rdata}`.
- `resp_wfull` in 1: response FIFO full.
- `resp_winc` out 1: response FIFO push.
- `psel`, `penable`, `pwrite` out 1: APB3 control.
- `paddr` out `ADDR_W`, `pwdata` out `DATA_W`: APB3 address and write data.
- `prdata` in `DATA_W`, `pready` in 1, `pslverr` in 1: APB3 slave return signals.
- `busy` out 1: high in any state other than IDLE.
- `timeout` out 1: one-cycle pulse when a transfer is force-terminated.

## Operation
- **FIFO read port behaviour:** `req_rdata` is registered inside the FIFO. It updates at the edge that ends the cycle in which the pop was issued, so it is valid one cycle after `req_rinc`.
- **States:** IDLE, LOAD, SETUP, ACCESS, RESP. All are one-hot or encoded, implementer's choice.
- **IDLE:**
  - `req_rinc = ~req_rempty` (combinational; 0 while `prst_n` is low).
  - If `req_rempty` is low, go to LOAD.
- **LOAD:**
  - Latch `req_rdata` into internal `write`, `addr` and `wdata` registers.
  - Go to SETUP.
- **SETUP:**
  - `psel=1`, `penable=0`.
  - `paddr`, `pwrite` and `pwdata` driven from the latched registers.
  - Go to ACCESS.
- **ACCESS:**
  - `psel=1`, `penable=1`; address, control and data held stable.
  - When `pready=1`:
    - Capture `slverr = pslverr`.
    - Capture `rdata = write ? 0 : prdata`.
    - Go to RESP.
- **RESP:**
  - `psel=0`, `penable=0`.
  - `resp_winc = ~resp_wfull`.
  - On the cycle `resp_winc=1`, go to IDLE; otherwise stay in RESP.
  - `resp_wdata` is held constant throughout RESP.
- **Hold behaviour:** `paddr`, `pwrite` and `pwdata` keep their last values outside transfers. `pwdata` is driven on reads too; it is don't-care to the slave.
- **Ignored inputs:** `pslverr` and `prdata` are ignored unless ACCESS and `pready=1`.
- **Reset values:**
  - `psel`, `penable`, `pwrite`, `busy`, `timeout`: 0.
  - `paddr`, `pwdata`, `resp_wdata`: 0.
  - State: IDLE.
- **Reset mid-operation:** `psel` and `penable` drop asynchronously. A request that has already been popped is discarded and no response is pushed. The AXI side is reset together with this block.

## Timing
- From `req_rempty` falling (sampled in IDLE) to `psel=1`: 2 cycles (pop, LOAD).
- Zero-wait-state transfer, pop to push, is 5 cycles: IDLE, LOAD, SETUP, ACCESS, RESP.
- Each low-`pready` cycle in ACCESS adds 1 cycle.
- Each `resp_wfull` cycle in RESP adds 1 cycle.
- Back-to-back throughput: one transfer per 5 cycles minimum. `psel` is low for at least 2 cycles (RESP, IDLE) between transfers.
- Exactly one pop and exactly one push per transfer.
- Never pop while `req_rempty=1`; never push while `resp_wfull=1`.

## Configuration
- Macro: `APB_TIMEOUT_EN`.
- **Defined:**
  - An ACCESS-cycle counter (`$clog2(TIMEOUT_CYCLES)+1` bits) clears in SETUP and increments each ACCESS cycle with `pready=0`.
  - If `pready` is still 0 on the `TIMEOUT_CYCLES`-th ACCESS cycle:
    - The transfer ends at that edge with `slverr=1`, `rdata=0`.
    - `timeout` pulses for that cycle.
    - The state goes to RESP.
  - A `pready=1` arriving on that same cycle wins: normal completion, no timeout.
- **Undefined:**
  - No counter is built and `timeout` is tied to 0.
  - ACCESS waits indefinitely for `pready`.

## Test plan
- **Zero-wait read:** request `{0, 0x0000_0010, x}`, slave returns `pready=1`, `prdata=0xCAFE_F00D` in the first ACCESS cycle.
  - One SETUP cycle, then one ACCESS cycle, with `paddr=0x10` and `pwrite=0`.
  - `resp_wdata=0x0_CAFE_F00D` pushed 5 cycles after the pop.
- **Wait-state write:** request `{1, 0x24, 0x1234_5678}`, slave holds `pready=0` for 3 cycles, then `pready=1` with `pslverr=1`.
  - ACCESS lasts 4 cycles; `pwdata` is stable throughout.
  - Response is `{1, 0x0}`.
- **Back-to-back:** 4 queued requests.
  - 4 pops and 4 pushes, in order.
  - `psel` is low for at least 2 cycles between transfers.
  - `penable` never rises without `psel`.
- **Response backpressure:** `resp_wfull=1` for 5 cycles during RESP.
  - `resp_winc` stays 0; the state holds RESP.
  - Push occurs in the first cycle after `resp_wfull` falls.
  - No new pop occurs meanwhile.
- **Reset mid-ACCESS:** assert `prst_n=0` during a wait state.
  - `psel` and `penable` go to 0 immediately; no response is pushed.
  - After release, the next request runs normally.
- **`APB_TIMEOUT_EN` with `TIMEOUT_CYCLES=8`:** slave never asserts `pready`.
  - Exactly 8 ACCESS cycles occur.
  - `timeout` pulses once.
  - Response is `{1, 0x0}`.
